// File: rtl/wl_pkg.sv
// Shared types for the word-line sequence driver: command opcodes, FSM states
// and the address-width helper used to size the command address port.
package wl_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'b00,
    OP_BCAST  = 2'b01,
    OP_REGION = 2'b10,
    OP_SINGLE = 2'b11
  } wl_op_e;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SETTLE,
    DONE
  } wl_state_e;

  // Width needed to address every word line; never narrower than one bit.
  function automatic int wl_aw(input int n_ch, input int n_reg);
    return (n_ch * n_reg > 1) ? $clog2(n_ch * n_reg) : 1;
  endfunction

endpackage

// File: rtl/wl_settle_timer.sv
// Settle countdown: loads SETTLE_CYC-1 when an apply finishes and counts down
// to zero, so the settle state lasts exactly SETTLE_CYC cycles.
module wl_settle_timer #(
  parameter int SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [CW-1:0] cnt;

  if (SETTLE_CYC < 1) begin : g_settle_check
    $error("wl_settle_timer: SETTLE_CYC must be >= 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SETTLE_CYC - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/wl_seq_driver.sv
// Word-line voltage driver: accepts one command at a time, writes the captured
// DAC voltages into the word-line bank, then waits out a settle interval.
module wl_seq_driver
  import wl_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int N_REG      = 4,
  parameter int SETTLE_CYC = 4,
  parameter int AW         = wl_aw(N_CH, N_REG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  real           op_vol [N_CH],
  output real           out_data [N_CH*N_REG],
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int N_WL = N_CH * N_REG;

  wl_state_e     state, state_next;
  wl_op_e        sh_op;
  logic [AW-1:0] sh_addr;
  real           sh_vol [N_CH];
  logic          err_flag;
  logic          accept;
  logic          settle_zero;
  logic [AW:0]   addr_ext, region, bit_idx;
  logic          addr_ok;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == DONE) && err_flag;
  assign accept    = cmd_valid && cmd_ready;

  // One extra address bit so region/bit math cannot overflow at any geometry.
  assign addr_ext = {1'b0, sh_addr};
  assign region   = addr_ext / (AW+1)'(N_CH);
  assign bit_idx  = addr_ext % (AW+1)'(N_CH);
  assign addr_ok  = (region < (AW+1)'(N_REG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = APPLY;
      APPLY:   state_next = SETTLE;
      SETTLE:  if (settle_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_op   <= OP_CLEAR;
      sh_addr <= '0;
      for (int j = 0; j < N_CH; j++) sh_vol[j] <= 0.0;
    end else if (accept) begin
      sh_op   <= wl_op_e'(cmd_op);
      sh_addr <= cmd_addr;
      for (int j = 0; j < N_CH; j++) sh_vol[j] <= op_vol[j];
    end
  end

  // Out-of-range region addresses write nothing and are reported with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
    end else if (state == APPLY) begin
      err_flag <= ((sh_op == OP_REGION) || (sh_op == OP_SINGLE)) && !addr_ok;
    end else if (state == DONE) begin
      err_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WL; i++) out_data[i] <= 0.0;
    end else if (state == APPLY) begin
      for (int r = 0; r < N_REG; r++) begin
        for (int j = 0; j < N_CH; j++) begin
          unique case (sh_op)
            OP_CLEAR: out_data[r*N_CH+j] <= 0.0;
            OP_BCAST: out_data[r*N_CH+j] <= sh_vol[j];
            OP_REGION: begin
              if (addr_ok && (region == (AW+1)'(r)))
                out_data[r*N_CH+j] <= sh_vol[j];
            end
            OP_SINGLE: begin
              if (addr_ok && (region == (AW+1)'(r)) && (bit_idx == (AW+1)'(j)))
                out_data[r*N_CH+j] <= sh_vol[j];
            end
            default: ;
          endcase
        end
      end
    end
  end

  wl_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state == APPLY),
    .dec  (state == SETTLE),
    .zero (settle_zero)
  );

endmodule

// File: tb/tb_wl_seq_driver.sv
// Scoreboard bench for wl_seq_driver: a default 8x4 instance and a 6x5 instance
// with SETTLE_CYC=1 to reach the out-of-range address path.
module tb_wl_seq_driver;
  import wl_pkg::*;

  localparam int NA_CH = 8, NA_REG = 4, NA_WL = 32, SA = 4, AWA = 5;
  localparam int NB_CH = 6, NB_REG = 5, NB_WL = 30, SB = 1, AWB = 5;
  // Edges from acceptance to the edge before the done cycle: SETTLE_CYC+1.
  localparam int LAT_A = 5, LAT_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n_a, valid_a, ready_a, busy_a, done_a, err_a;
  logic [1:0]     op_a;
  logic [AWA-1:0] addr_a;
  real            vol_a [NA_CH];
  real            out_a [NA_WL];

  logic           rst_n_b, valid_b, ready_b, busy_b, done_b, err_b;
  logic [1:0]     op_b;
  logic [AWB-1:0] addr_b;
  real            vol_b [NB_CH];
  real            out_b [NB_WL];

  int errors = 0, checks = 0, cyc = 0;
  int dones_a = 0, dones_b = 0, acc_last = 0, n_a = 0, n_b = 0;

  int id_qa[$], acc_qa[$], id_qb[$], acc_qb[$];
  bit err_qa[$], err_qb[$];
  real mdl_a [NA_WL];
  real mdl_b [NB_WL];
  real exp_a [64][NA_WL];
  real exp_b [64][NB_WL];
  real def_a [NA_CH] = '{0.1, 0.2, 0.3, 0.4, 0.5, 0.6, 0.7, 0.8};
  real def_b [NB_CH] = '{1.0, 2.0, 3.0, 4.0, 5.0, 6.0};

  wl_seq_driver #(.N_CH(NA_CH), .N_REG(NA_REG), .SETTLE_CYC(SA)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .cmd_valid(valid_a), .cmd_ready(ready_a),
    .cmd_op(op_a), .cmd_addr(addr_a), .op_vol(vol_a), .out_data(out_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  wl_seq_driver #(.N_CH(NB_CH), .N_REG(NB_REG), .SETTLE_CYC(SB)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_op(op_b), .cmd_addr(addr_b), .op_vol(vol_b), .out_data(out_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input real act, input real exp);
    checks++;
    if ((act - exp > 1e-9) || (exp - act > 1e-9)) begin
      errors++;
      $display("[TB] FAIL %s: got %f expected %f", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Drive one command into instance A; the expected bank is pushed at acceptance.
  task automatic apply_stimulus_a(input logic [1:0] op, input int addr, input bit hold);
    int n = 0;
    op_a = op; addr_a = AWA'(addr); valid_a = 1'b1;
    while (!ready_a && n < 50) begin @(negedge clk); n++; end
    if (!ready_a) begin fail_now("ready_wait_a"); valid_a = 1'b0; return; end
    @(posedge clk); #1;
    acc_last = cyc;
    case (op)
      2'b00: for (int i = 0; i < NA_WL; i++) mdl_a[i] = 0.0;
      2'b01: for (int i = 0; i < NA_WL; i++) mdl_a[i] = vol_a[i % NA_CH];
      2'b10: for (int j = 0; j < NA_CH; j++) mdl_a[(addr / NA_CH) * NA_CH + j] = vol_a[j];
      default: mdl_a[addr] = vol_a[addr % NA_CH];
    endcase
    for (int i = 0; i < NA_WL; i++) exp_a[n_a][i] = mdl_a[i];
    id_qa.push_back(n_a); acc_qa.push_back(acc_last); err_qa.push_back(1'b0);
    n_a = (n_a + 1) % 64;
    if (!hold) valid_a = 1'b0;
  endtask

  task automatic apply_stimulus_b(input logic [1:0] op, input int addr);
    int n = 0;
    bit bad_addr;
    op_b = op; addr_b = AWB'(addr); valid_b = 1'b1;
    while (!ready_b && n < 50) begin @(negedge clk); n++; end
    if (!ready_b) begin fail_now("ready_wait_b"); valid_b = 1'b0; return; end
    @(posedge clk); #1;
    bad_addr = (op >= 2'b10) && (addr / NB_CH >= NB_REG);
    if (!bad_addr) begin
      case (op)
        2'b00: for (int i = 0; i < NB_WL; i++) mdl_b[i] = 0.0;
        2'b01: for (int i = 0; i < NB_WL; i++) mdl_b[i] = vol_b[i % NB_CH];
        2'b10: for (int j = 0; j < NB_CH; j++) mdl_b[(addr / NB_CH) * NB_CH + j] = vol_b[j];
        default: mdl_b[addr] = vol_b[addr % NB_CH];
      endcase
    end
    for (int i = 0; i < NB_WL; i++) exp_b[n_b][i] = mdl_b[i];
    id_qb.push_back(n_b); acc_qb.push_back(cyc); err_qb.push_back(bad_addr);
    n_b = (n_b + 1) % 64;
    valid_b = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((id_qa.size() != 0 || busy_a) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_now("idle_wait_a");
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while ((id_qb.size() != 0 || busy_b) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_now("idle_wait_b");
  endtask

  // Monitors: every done pulse pops one expected response.
  always @(negedge clk) begin
    int id, acc, bad;
    bit e;
    if (rst_n_a && err_a && !done_a) fail_now("err_without_done_a");
    if (rst_n_a && done_a) begin
      dones_a++;
      if (id_qa.size() == 0) begin
        fail_now("unexpected_done_a");
      end else begin
        id = id_qa.pop_front(); acc = acc_qa.pop_front(); e = err_qa.pop_front();
        check_output("latency_a", cyc - acc, LAT_A);
        check_output("err_a", err_a, e);
        bad = 0;
        for (int i = 0; i < NA_WL; i++) if (out_a[i] != exp_a[id][i]) bad++;
        check_output("data_a_bad_entries", bad, 0);
      end
    end
  end

  always @(negedge clk) begin
    int id, acc, bad;
    bit e;
    if (rst_n_b && err_b && !done_b) fail_now("err_without_done_b");
    if (rst_n_b && done_b) begin
      dones_b++;
      if (id_qb.size() == 0) begin
        fail_now("unexpected_done_b");
      end else begin
        id = id_qb.pop_front(); acc = acc_qb.pop_front(); e = err_qb.pop_front();
        check_output("latency_b", cyc - acc, LAT_B);
        check_output("err_b", err_b, e);
        bad = 0;
        for (int i = 0; i < NB_WL; i++) if (out_b[i] != exp_b[id][i]) bad++;
        check_output("data_b_bad_entries", bad, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb, a1, a2, a3, d0;
    rst_n_a = 1'b0; rst_n_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    op_a = '0; addr_a = '0; op_b = '0; addr_b = '0;
    for (int j = 0; j < NA_CH; j++) vol_a[j] = def_a[j];
    for (int j = 0; j < NB_CH; j++) vol_b[j] = def_b[j];
    for (int i = 0; i < NA_WL; i++) mdl_a[i] = 0.0;
    for (int i = 0; i < NB_WL; i++) mdl_b[i] = 0.0;
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);
    nb = 0;
    for (int i = 0; i < NA_WL; i++) if (out_a[i] != 0.0) nb++;
    check_output("reset_out_nonzero", nb, 0);
    check_output("reset_busy", busy_a, 0);
    check_output("reset_done", done_a, 0);
    check_output("reset_err", err_a, 0);
    check_output("reset_ready", ready_a, 1);

    // Broadcast of default voltages, with busy window and first-valid timing.
    apply_stimulus_a(2'b01, 0, 1'b0);
    nb = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy_a && !ready_a) nb++;
      if (k == 0) check_output("bcast_before_apply", out_a[0], 0.0);
      if (k == 1) begin
        for (int r = 0; r < NA_REG; r++) begin
          check_output("bcast_r_j0", out_a[r*8], 0.1);
          check_output("bcast_r_j7", out_a[r*8+7], 0.8);
        end
        check_output("bcast_wl10", out_a[10], 0.3);
      end
    end
    check_output("busy_window", nb, 6);
    @(negedge clk);
    check_output("busy_after_done", busy_a, 0);
    check_output("ready_after_done", ready_a, 1);

    // Single write; voltages changed after acceptance must not leak in.
    vol_a[3] = 1.5;
    apply_stimulus_a(2'b11, 19, 1'b0);
    for (int j = 0; j < NA_CH; j++) vol_a[j] = 9.9;
    wait_idle_a();
    check_output("single_wl19", out_a[19], 1.5);
    check_output("single_wl18_hold", out_a[18], 0.3);
    check_output("single_wl3_hold", out_a[3], 0.4);

    for (int j = 0; j < NA_CH; j++) vol_a[j] = 0.9;
    apply_stimulus_a(2'b10, 17, 1'b0);
    wait_idle_a();
    check_output("region_wl16", out_a[16], 0.9);
    check_output("region_wl23", out_a[23], 0.9);
    check_output("region_wl15_hold", out_a[15], 0.8);
    check_output("region_wl24_hold", out_a[24], 0.1);

    apply_stimulus_a(2'b00, 5, 1'b0);
    wait_idle_a();
    nb = 0;
    for (int i = 0; i < NA_WL; i++) if (out_a[i] != 0.0) nb++;
    check_output("clear_nonzero", nb, 0);

    // Three commands with cmd_valid held high throughout.
    for (int j = 0; j < NA_CH; j++) vol_a[j] = def_a[j];
    d0 = dones_a;
    apply_stimulus_a(2'b01, 0, 1'b1);  a1 = acc_last;
    apply_stimulus_a(2'b11, 3, 1'b1);  a2 = acc_last;
    apply_stimulus_a(2'b10, 30, 1'b0); a3 = acc_last;
    wait_idle_a();
    check_output("b2b_gap_1", a2 - a1, 7);
    check_output("b2b_gap_2", a3 - a2, 7);
    check_output("b2b_done_count", dones_a - d0, 3);

    // Reset during settle: bank cleared at once, pending command abandoned.
    apply_stimulus_a(2'b01, 0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check_output("pre_reset_wl0", out_a[0], 0.1);
    rst_n_a = 1'b0;
    #1;
    nb = 0;
    for (int i = 0; i < NA_WL; i++) if (out_a[i] != 0.0) nb++;
    check_output("midreset_nonzero", nb, 0);
    id_qa.delete(); acc_qa.delete(); err_qa.delete();
    for (int i = 0; i < NA_WL; i++) mdl_a[i] = 0.0;
    d0 = dones_a;
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
    @(negedge clk);
    check_output("ready_after_reset", ready_a, 1);
    check_output("busy_after_reset", busy_a, 0);
    repeat (8) @(negedge clk);
    check_output("no_done_after_reset", dones_a - d0, 0);

    // 6x5 geometry: in-range writes, then addresses beyond the last region.
    apply_stimulus_b(2'b01, 0);
    wait_idle_b();
    vol_b[5] = 7.0;
    apply_stimulus_b(2'b11, 29);
    wait_idle_b();
    check_output("b_single_wl29", out_b[29], 7.0);
    d0 = dones_b;
    apply_stimulus_b(2'b11, 31);
    wait_idle_b();
    apply_stimulus_b(2'b10, 30);
    wait_idle_b();
    check_output("b_err_done_count", dones_b - d0, 2);
    check_output("b_wl29_hold", out_b[29], 7.0);
    check_output("b_wl24_hold", out_b[24], 1.0);
    check_output("b_wl0_hold", out_b[0], 1.0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
